// File: rtl/cgra_cfg_loader.sv
// CSR-mapped per-tile context store that streams contexts 0..KLEN-1 to every CGRA tile
// in lockstep. It also provides wptr/status/KLEN readback and sticky error flags.
module cgra_cfg_loader #(
  parameter int NumTiles     = 16,
  parameter int KernelSize   = 4,
  parameter int CfgWidth     = 49,
  parameter int RegDataWidth = 64,
  parameter int RegAddrWidth = 32,
  localparam int IdxW        = $clog2(KernelSize)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [RegAddrWidth-1:0]      csr_addr_i,
  input  logic [RegDataWidth-1:0]      csr_wr_data_i,
  input  logic                         csr_wr_en_i,
  input  logic                         csr_req_valid_i,
  output logic                         csr_req_ready_o,
  output logic [RegDataWidth-1:0]      csr_rd_data_o,
  output logic                         csr_rsp_valid_o,
  input  logic                         csr_rsp_ready_i,
  output logic [NumTiles*IdxW-1:0]     tile_addr_o,
  output logic [NumTiles*CfgWidth-1:0] tile_data_o,
  output logic [NumTiles-1:0]          tile_valid_o,
  input  logic [NumTiles-1:0]          tile_ready_i,
  output logic                         load_done_o
);

  localparam int PtrW  = IdxW + 1;
  localparam int TileW = (NumTiles > 1) ? $clog2(NumTiles) : 1;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [CfgWidth-1:0] mem_q [NumTiles][KernelSize];
  logic [PtrW-1:0]     wptr_q [NumTiles];
  logic [PtrW-1:0]     klen_q;
  logic                done_q, addr_err_q, busy_err_q, ovf_q;
  logic [IdxW-1:0]     idx_q, last_q, idx_nxt;
  logic                rsp_valid_q;
  logic [RegDataWidth-1:0] rd_data_q, rd_val;

  logic              acc, wr_acc, busy, all_ready, beat_fire, last_beat;
  logic              is_tile, is_ctrl, is_status, is_klen;
  logic              start_go, clear_go;
  logic [TileW-1:0]  tile_sel;
  logic [PtrW-1:0]   klen_wr;
  logic              klen_legal;
  logic [4:0]        status_vec;
  logic              unused_wr_data;

  // CSR handshake: a request is taken on req_valid & req_ready, where req_ready is high
  // whenever no response is pending or the pending one is consumed this cycle. The
  // response appears the cycle after acceptance and holds until rsp_ready.
  assign csr_req_ready_o = !rsp_valid_q || csr_rsp_ready_i;
  assign csr_rsp_valid_o = rsp_valid_q;
  assign csr_rd_data_o   = rd_data_q;
  assign unused_wr_data  = ^csr_wr_data_i;

  always_comb begin
    acc        = csr_req_valid_i && csr_req_ready_o;
    wr_acc     = acc && csr_wr_en_i;
    is_tile    = csr_addr_i < RegAddrWidth'(NumTiles);
    is_ctrl    = csr_addr_i == RegAddrWidth'(NumTiles);
    is_status  = csr_addr_i == RegAddrWidth'(NumTiles + 1);
    is_klen    = csr_addr_i == RegAddrWidth'(NumTiles + 2);
    tile_sel   = csr_addr_i[TileW-1:0];
    klen_wr    = csr_wr_data_i[IdxW:0];
    klen_legal = (klen_wr != '0) && (klen_wr <= PtrW'(KernelSize));
    busy       = (state_q == S_STREAM);
    all_ready  = &tile_ready_i;
    beat_fire  = busy && all_ready;
    last_beat  = beat_fire && (idx_q == last_q);
    idx_nxt    = idx_q + IdxW'(1);
    start_go   = wr_acc && is_ctrl && csr_wr_data_i[0] && !busy;
    clear_go   = wr_acc && is_ctrl && csr_wr_data_i[1] && !busy;
    status_vec = {ovf_q, busy_err_q, addr_err_q, done_q, busy};
  end

  always_comb begin
    rd_val = '0;
    if (is_tile) begin
      rd_val = RegDataWidth'(wptr_q[tile_sel]);
    end else if (is_status) begin
      rd_val = RegDataWidth'(status_vec);
    end else if (is_klen) begin
      rd_val = RegDataWidth'(klen_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_go) state_d = S_STREAM;
      S_STREAM: if (last_beat) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rd_data_q   <= '0;
    end else if (acc) begin
      rsp_valid_q <= 1'b1;
      rd_data_q   <= csr_wr_en_i ? '0 : rd_val;
    end else if (csr_rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // Context memory, write pointers, KLEN and sticky status. A CLEAR in the same write
  // as START takes effect first, so the new load starts from a clean status.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int t = 0; t < NumTiles; t++) begin
        wptr_q[t] <= '0;
        for (int k = 0; k < KernelSize; k++) begin
          mem_q[t][k] <= '0;
        end
      end
      klen_q     <= PtrW'(KernelSize);
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      busy_err_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (wr_acc) begin
        if (is_tile) begin
          if (busy) begin
            busy_err_q <= 1'b1;
          end else if (wptr_q[tile_sel] == PtrW'(KernelSize)) begin
            ovf_q <= 1'b1;
          end else begin
            mem_q[tile_sel][wptr_q[tile_sel][IdxW-1:0]] <= csr_wr_data_i[CfgWidth-1:0];
            wptr_q[tile_sel] <= wptr_q[tile_sel] + PtrW'(1);
          end
        end else if (is_ctrl) begin
          if (csr_wr_data_i[1] && busy) begin
            busy_err_q <= 1'b1;
          end else if (clear_go) begin
            for (int t = 0; t < NumTiles; t++) begin
              wptr_q[t] <= '0;
            end
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            busy_err_q <= 1'b0;
            ovf_q      <= 1'b0;
          end
        end else if (is_status) begin
          if (csr_wr_data_i[1]) done_q     <= 1'b0;
          if (csr_wr_data_i[2]) addr_err_q <= 1'b0;
          if (csr_wr_data_i[3]) busy_err_q <= 1'b0;
          if (csr_wr_data_i[4]) ovf_q      <= 1'b0;
        end else if (is_klen) begin
          if (klen_legal) begin
            klen_q <= klen_wr;
          end else begin
            addr_err_q <= 1'b1;
          end
        end else begin
          addr_err_q <= 1'b1;
        end
      end
      if (last_beat) done_q <= 1'b1;
    end
  end

  // Stream registers; the last index is latched at START so a KLEN write mid-load
  // cannot change the length of the load in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q        <= '0;
      last_q       <= '0;
      tile_valid_o <= '0;
      tile_addr_o  <= '0;
      tile_data_o  <= '0;
      load_done_o  <= 1'b0;
    end else begin
      load_done_o <= 1'b0;
      if (start_go) begin
        idx_q        <= '0;
        last_q       <= IdxW'(klen_q - PtrW'(1));
        tile_valid_o <= '1;
        tile_addr_o  <= '0;
        for (int t = 0; t < NumTiles; t++) begin
          tile_data_o[t*CfgWidth +: CfgWidth] <= mem_q[t][0];
        end
      end else if (last_beat) begin
        idx_q        <= '0;
        tile_valid_o <= '0;
        tile_addr_o  <= '0;
        tile_data_o  <= '0;
        load_done_o  <= 1'b1;
      end else if (beat_fire) begin
        idx_q <= idx_nxt;
        for (int t = 0; t < NumTiles; t++) begin
          tile_addr_o[t*IdxW +: IdxW]         <= idx_nxt;
          tile_data_o[t*CfgWidth +: CfgWidth] <= mem_q[t][idx_nxt];
        end
      end
    end
  end

endmodule
